// File: rtl/mxint_packer_if.sv
// Stream bundle for mxint_packer: fixed-point beats in, shared-exponent
// mantissa beats out. The slave modport is the packer, the master is its environment.
interface mxint_packer_if #(
  parameter int IN_WIDTH   = 8,
  parameter int MAN_WIDTH  = 4,
  parameter int EXP_WIDTH  = 4,
  parameter int BLOCK_SIZE = 2
);
  logic [BLOCK_SIZE-1:0][IN_WIDTH-1:0]  data_in;
  logic                                 data_in_valid;
  logic                                 data_in_ready;
  logic [BLOCK_SIZE-1:0][MAN_WIDTH-1:0] mdata_out;
  logic signed [EXP_WIDTH-1:0]          edata_out;
  logic                                 data_out_valid;
  logic                                 data_out_ready;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, mdata_out, edata_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, mdata_out, edata_out, data_out_valid
  );
endinterface

// File: rtl/mxint_packer.sv
// Packs BLOCK_DEPTH fixed-point beats into MX-int form: one shared exponent plus
// per-element signed mantissas. Define MXINT_PACKER_ROUND_EN for round-half-up right shifts.
module mxint_packer #(
  parameter int IN_WIDTH      = 8,
  parameter int IN_FRAC_WIDTH = 4,
  parameter int MAN_WIDTH     = 4,
  parameter int EXP_WIDTH     = 4,
  parameter int BLOCK_SIZE    = 2,
  parameter int BLOCK_DEPTH   = 2
) (
  input logic            clk,
  input logic            rst,
  mxint_packer_if.slave  bus
);
  localparam int CNT_W = (BLOCK_DEPTH > 1) ? $clog2(BLOCK_DEPTH) : 1;
  localparam int SH_W  = EXP_WIDTH + $clog2(IN_FRAC_WIDTH + MAN_WIDTH + 1) + 2;
  localparam int WW    = IN_WIDTH + 2**(EXP_WIDTH-1) + MAN_WIDTH + 1;
  localparam int EMIN  = -(2**(EXP_WIDTH-1));
  localparam int EMAX  = 2**(EXP_WIDTH-1) - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_DEPTH-1);
  localparam logic signed [WW-1:0] MAX_W = WW'(2**(MAN_WIDTH-1) - 1);
  localparam logic signed [WW-1:0] MIN_W = -MAX_W;

  typedef enum logic [1:0] {COLLECT, CALC, EMIT} state_t;

  state_t                              state, state_nxt;
  logic [CNT_W-1:0]                    wr_cnt, rd_cnt;
  logic [IN_WIDTH-1:0]                 acc_or, beat_or;
  logic signed [EXP_WIDTH-1:0]         e_p1, e_nxt;
  logic signed [SH_W-1:0]              sh_p1, sh_nxt;
  logic [BLOCK_SIZE-1:0][IN_WIDTH-1:0] buffer [BLOCK_DEPTH];
  logic                                in_fire, out_fire;

  // Unsigned magnitude: the most negative input maps to 2^(IN_WIDTH-1) without overflow.
  function automatic logic [IN_WIDTH-1:0] mag(input logic [IN_WIDTH-1:0] x);
    return x[IN_WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic int lead_one(input logic [IN_WIDTH-1:0] v);
    int p;
    p = -1;
    for (int k = 0; k < IN_WIDTH; k++)
      if (v[k]) p = k;
    return p;
  endfunction

  function automatic logic signed [MAN_WIDTH-1:0] sat(input logic signed [WW-1:0] w);
    if (w > MAX_W) return MAN_WIDTH'(MAX_W);
    if (w < MIN_W) return MAN_WIDTH'(MIN_W);
    return MAN_WIDTH'(w);
  endfunction

  function automatic logic signed [MAN_WIDTH-1:0] to_man(input logic signed [IN_WIDTH-1:0] x,
                                                         input logic signed [SH_W-1:0]     s);
    logic signed [WW-1:0] w;
    w = WW'(x);
    if (s < 0) begin
      w = w <<< (-s);
    end else begin
`ifdef MXINT_PACKER_ROUND_EN
      if (s > 0) w = w + (WW'(1) << (s - SH_W'(1)));
`endif
      w = w >>> s;
    end
    return sat(w);
  endfunction

  assign in_fire  = bus.data_in_valid && bus.data_in_ready;
  assign out_fire = bus.data_out_valid && bus.data_out_ready;

  always_comb begin
    beat_or = '0;
    for (int i = 0; i < BLOCK_SIZE; i++)
      beat_or = beat_or | mag(bus.data_in[i]);
  end

  // CALC stage: shared exponent from the block's leading one, and the mantissa shift.
  always_comb begin
    int e_int, sh_int;
    e_int = lead_one(acc_or) - IN_FRAC_WIDTH;
    if (e_int < EMIN) e_int = EMIN;
    if (e_int > EMAX) e_int = EMAX;
    if (acc_or == '0) e_int = 0;
    sh_int = e_int + IN_FRAC_WIDTH - (MAN_WIDTH - 2);
    e_nxt  = EXP_WIDTH'(e_int);
    sh_nxt = SH_W'(sh_int);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (in_fire && wr_cnt == LAST) state_nxt = CALC;
      CALC:    state_nxt = EMIT;
      EMIT:    if (out_fire && rd_cnt == LAST) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= COLLECT;
      wr_cnt <= '0;
      rd_cnt <= '0;
      acc_or <= '0;
      e_p1   <= '0;
      sh_p1  <= '0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        acc_or <= acc_or | beat_or;
      end
      if (state == CALC) begin
        e_p1  <= e_nxt;
        sh_p1 <= sh_nxt;
      end
      if (out_fire) begin
        if (rd_cnt == LAST) begin
          rd_cnt <= '0;
          wr_cnt <= '0;
          acc_or <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) buffer[wr_cnt] <= bus.data_in;
  end

  // EMIT stage: outputs derive from held registers, so they stay stable under backpressure.
  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++)
      bus.mdata_out[i] = to_man(buffer[rd_cnt][i], sh_p1);
    bus.edata_out      = e_p1;
    bus.data_out_valid = (state == EMIT);
    bus.data_in_ready  = (state == COLLECT);
  end
endmodule

// File: tb/tb_mxint_packer.sv
// Directed bench for mxint_packer at default parameters; expected values are hand-derived.
module tb_mxint_packer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mxint_packer_if #(.IN_WIDTH(8), .MAN_WIDTH(4), .EXP_WIDTH(4), .BLOCK_SIZE(2)) bus ();

  mxint_packer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    bus.data_in_valid  = 1'b0;
    bus.data_out_ready = 1'b0;
    bus.data_in        = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_beat(input string tag, input int x0, input int x1);
    int n;
    @(negedge clk);
    bus.data_in[0]    = 8'(x0);
    bus.data_in[1]    = 8'(x1);
    bus.data_in_valid = 1'b1;
    n = 0;
    while (!bus.data_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_rdy"}, int'(bus.data_in_ready), 1);
    @(posedge clk);
    #1 bus.data_in_valid = 1'b0;
  endtask

  // Sends a two-beat block and checks the two-cycle gap before the first output beat.
  task automatic send_block(input string tag, input int a0, input int a1, input int b0, input int b1);
    send_beat(tag, a0, a1);
    send_beat(tag, b0, b1);
    @(negedge clk);
    check({tag, "_calc_vld"}, int'(bus.data_out_valid), 0);
    check({tag, "_calc_rdy"}, int'(bus.data_in_ready), 0);
    @(negedge clk);
    check({tag, "_lat_vld"}, int'(bus.data_out_valid), 1);
  endtask

  task automatic recv_beat(input string tag, input int e, input int m0, input int m1);
    int n;
    n = 0;
    while (!bus.data_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_vld"}, int'(bus.data_out_valid), 1);
    check({tag, "_exp"}, int'(bus.edata_out), e);
    check({tag, "_m0"}, int'($signed(bus.mdata_out[0])), m0);
    check({tag, "_m1"}, int'($signed(bus.mdata_out[1])), m1);
    check({tag, "_in_rdy"}, int'(bus.data_in_ready), 0);
    bus.data_out_ready = 1'b1;
    @(posedge clk);
    #1 bus.data_out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic block_done(input string tag);
    check({tag, "_done_vld"}, int'(bus.data_out_valid), 0);
    check({tag, "_done_rdy"}, int'(bus.data_in_ready), 1);
  endtask

  initial begin
    int r1;
`ifdef MXINT_PACKER_ROUND_EN
    r1 = 2;
`else
    r1 = 1;
`endif
    do_reset();
    check("rst_vld", int'(bus.data_out_valid), 0);
    check("rst_rdy", int'(bus.data_in_ready), 1);
    check("rst_exp", int'(bus.edata_out), 0);

    // Mixed block, shift right by 2
    send_block("basic", 16, -3, 6, 0);
    recv_beat("basic_b0", 0, 4, -1);
    recv_beat("basic_b1", 0, r1, 0);
    block_done("basic");

    // Tiny value, left shift by 2
    do_reset();
    send_block("small", 1, 0, 0, 0);
    recv_beat("small_b0", -4, 4, 0);
    recv_beat("small_b1", -4, 0, 0);
    block_done("small");

    // Positive saturation (rounding overflow when enabled)
    do_reset();
    send_block("satp", 15, 0, 0, 0);
    recv_beat("satp_b0", -1, 7, 0);
    recv_beat("satp_b1", -1, 0, 0);
    block_done("satp");

    // Negative saturation to -7
    do_reset();
    send_block("satn", -15, 0, 0, 0);
    recv_beat("satn_b0", -1, -7, 0);
    recv_beat("satn_b1", -1, 0, 0);
    block_done("satn");

    // Most negative input: magnitude 128, exponent 3, shift 5
    do_reset();
    send_block("minval", -128, 0, 0, 0);
    recv_beat("minval_b0", 3, -4, 0);
    recv_beat("minval_b1", 3, 0, 0);
    block_done("minval");

    // All-zero block
    do_reset();
    send_block("zero", 0, 0, 0, 0);
    recv_beat("zero_b0", 0, 0, 0);
    recv_beat("zero_b1", 0, 0, 0);
    block_done("zero");

    // Backpressure: three stalled cycles with outputs held
    do_reset();
    send_block("stall", 16, -3, 6, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_vld", int'(bus.data_out_valid), 1);
      check("stall_exp", int'(bus.edata_out), 0);
      check("stall_m0", int'($signed(bus.mdata_out[0])), 4);
      check("stall_m1", int'($signed(bus.mdata_out[1])), -1);
      check("stall_in_rdy", int'(bus.data_in_ready), 0);
    end
    recv_beat("stall_b0", 0, 4, -1);
    recv_beat("stall_b1", 0, r1, 0);
    block_done("stall");

    // Reset in the middle of EMIT, then a fresh block
    do_reset();
    send_block("mid", 16, -3, 6, 0);
    recv_beat("mid_b0", 0, 4, -1);
    rst = 1'b0;
    #1;
    check("mid_rst_vld", int'(bus.data_out_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rel_rdy", int'(bus.data_in_ready), 1);
    check("mid_rel_vld", int'(bus.data_out_valid), 0);
    check("mid_rel_exp", int'(bus.edata_out), 0);
    send_block("fresh", 16, -3, 6, 0);
    recv_beat("fresh_b0", 0, 4, -1);
    recv_beat("fresh_b1", 0, r1, 0);
    block_done("fresh");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
